// File: rtl/preclr_pkg.sv
// preclr_pkg: shared op encodings, FSM states and sizing helper
// for the preset/clear pulse sequencer.
package preclr_pkg;

  typedef enum logic [1:0] {
    OP_RSVD   = 2'b00,
    OP_CLEAR  = 2'b01,
    OP_PRESET = 2'b10,
    OP_WRITE  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    ASSERT,
    GUARD,
    DONE
  } state_e;

  function automatic int cnt_w(input int p, input int g);
    int m;
    m = (p > g) ? p : g;
    if (m < 1) m = 1;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/seq_cycle_counter.sv
// seq_cycle_counter: loadable down-counter that holds at zero
// and flags it; times the pulse and guard phases.
module seq_cycle_counter
  import preclr_pkg::*;
#(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/preclr_sequencer.sv
// preclr_sequencer: turns clear/preset/write requests into
// fixed-width active-low pulses, a guard gap and a done strobe.
module preclr_sequencer
  import preclr_pkg::*;
#(
  parameter int N       = 8,
  parameter int PULSE_W = 2,
  parameter int GUARD_W = 1
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [1:0]   req_op,
  input  logic [N-1:0] req_mask,
  input  logic [N-1:0] req_data,
  output logic [N-1:0] pre_n,
  output logic [N-1:0] clr_n,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam int CW = cnt_w(PULSE_W, GUARD_W);
  localparam logic [CW-1:0] PLOAD = CW'(PULSE_W - 1);
  localparam logic [CW-1:0] GLOAD =
    CW'((GUARD_W > 0) ? GUARD_W - 1 : 0);

  state_e       state, state_d;
  op_e          op_q, op_s;
  logic [N-1:0] mask_q, data_q;
  logic [N-1:0] mask_s, data_s;
  logic [N-1:0] pre_d, clr_d;
  logic         accept;
  logic         load;
  logic [CW-1:0] load_val;
  logic         zero;

  seq_cycle_counter #(.W(CW)) u_cnt (
    .clk      (clk),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .zero     (zero)
  );

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state  <= IDLE;
      op_q   <= OP_RSVD;
      mask_q <= '0;
      data_q <= '0;
    end else begin
      state <= state_d;
      if (accept) begin
        op_q   <= op_e'(req_op);
        mask_q <= req_mask;
        data_q <= req_data;
      end
    end
  end

  always_comb begin
    state_d  = state;
    load     = 1'b0;
    load_val = '0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (op_e'(req_op) == OP_RSVD) begin
            state_d = DONE;
          end else begin
            state_d  = ASSERT;
            load     = 1'b1;
            load_val = PLOAD;
          end
        end
      end
      ASSERT: begin
        if (zero) begin
          if (GUARD_W == 0) begin
            state_d = DONE;
          end else begin
            state_d  = GUARD;
            load     = 1'b1;
            load_val = GLOAD;
          end
        end
      end
      GUARD: begin
        if (zero) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Pulse lines are registered from the next state so they go low
  // on the accept edge itself, using the request being latched.
  always_comb begin
    op_s   = accept ? op_e'(req_op) : op_q;
    mask_s = accept ? req_mask : mask_q;
    data_s = accept ? req_data : data_q;
    pre_d  = '1;
    clr_d  = '1;
    if (state_d == ASSERT) begin
      unique case (1'b1)
        (op_s == OP_CLEAR):  clr_d = ~mask_s;
        (op_s == OP_PRESET): pre_d = ~mask_s;
        (op_s == OP_WRITE): begin
          clr_d = ~(mask_s & ~data_s);
          pre_d = ~(mask_s & data_s);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      pre_n <= '1;
      clr_n <= '1;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      pre_n <= pre_d;
      clr_n <= clr_d;
      done  <= (state_d == DONE);
      err   <= (state_d == DONE) && (op_s == OP_RSVD);
    end
  end

endmodule

// File: tb/tb_preclr_sequencer.sv
// tb_preclr_sequencer: directed and random requests checked each
// cycle against a phase-count model of the pulse sequence.
module tb_preclr_sequencer;

  localparam int N = 8;
  localparam int P = 2;
  localparam int G = 1;

  logic         clk = 1'b0;
  logic         clr = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [1:0]   req_op = 2'b00;
  logic [N-1:0] req_mask = '0;
  logic [N-1:0] req_data = '0;
  logic [N-1:0] pre_n, clr_n;
  logic         busy, done, err;

  preclr_sequencer #(.N(N), .PULSE_W(P), .GUARD_W(G)) dut (
    .clk       (clk),
    .clr       (clr),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_mask  (req_mask),
    .req_data  (req_data),
    .pre_n     (pre_n),
    .clr_n     (clr_n),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int edge_no = 0;

  bit           m_active = 0;
  int           m_t = 0;
  logic [1:0]   m_op;
  logic [N-1:0] m_mask, m_data;
  logic [N-1:0] e_pre, e_clr;
  logic         e_busy, e_done, e_err, e_ready;
  logic         obs_ready;
  int           dacc_q[$];
  int           done_edge = -1;

  // Behavioural flip-flop bank driven by the async pins.
  logic [N-1:0] bank = '0;
  always @(pre_n, clr_n) begin
    for (int i = 0; i < N; i++) begin
      if (pre_n[i] === 1'b0) bank[i] = 1'b1;
      else if (clr_n[i] === 1'b0) bank[i] = 1'b0;
    end
  end

  function automatic void model_expect();
    e_pre   = '1;
    e_clr   = '1;
    e_busy  = m_active;
    e_done  = 1'b0;
    e_err   = 1'b0;
    e_ready = !m_active;
    if (m_active) begin
      if (m_op == 2'b00) begin
        e_done = 1'b1;
        e_err  = 1'b1;
      end else if (m_t < P) begin
        for (int i = 0; i < N; i++) begin
          if (m_mask[i]) begin
            if (m_op == 2'b01) e_clr[i] = 1'b0;
            else if (m_op == 2'b10) e_pre[i] = 1'b0;
            else if (m_data[i]) e_pre[i] = 1'b0;
            else e_clr[i] = 1'b0;
          end
        end
      end else if (m_t == P + G) begin
        e_done = 1'b1;
      end
    end
  endfunction

  task automatic step();
    obs_ready = req_ready;
    @(posedge clk);
    edge_no++;
    if (!clr) begin
      m_active = 0;
    end else begin
      if (obs_ready && req_valid) dacc_q.push_back(edge_no);
      if (m_active) begin
        m_t++;
        if (m_op == 2'b00 || m_t > P + G) m_active = 0;
      end else if (req_valid) begin
        m_active = 1;
        m_t      = 0;
        m_op     = req_op;
        m_mask   = req_mask;
        m_data   = req_data;
      end
    end
    @(negedge clk);
    model_expect();
    if (done === 1'b1 && done_edge < 0) done_edge = edge_no;
  endtask

  task automatic test_reset();
    clr = 1'b0;
    for (int c = 0; c < 4; c++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_op    = 2'($urandom_range(0, 3));
      req_mask  = N'($urandom);
      req_data  = N'($urandom);
      step();
      checks++;
      if ({pre_n, clr_n, busy, done, err, req_ready} !==
          {8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1}) begin
        failures++;
        $display("FAIL reset got pre=%h clr=%h bdr=%b%b%b%b want FF FF 0001",
                 pre_n, clr_n, busy, done, err, req_ready);
      end
    end
    req_valid = 1'b0;
    clr = 1'b1;
  endtask

  task automatic test_clear();
    int acc;
    req_valid = 1'b1;
    req_op    = 2'b01;
    req_mask  = 8'h0F;
    done_edge = -1;
    for (int c = 0; c < 6; c++) begin
      step();
      if (c == 0) acc = edge_no;
      req_valid = 1'b0;
      req_mask  = 8'hFF;
      checks++;
      if ({pre_n, clr_n, busy, done, err, req_ready} !==
          {e_pre, e_clr, e_busy, e_done, e_err, e_ready}) begin
        failures++;
        $display("FAIL clear c=%0d got %h %h %b%b%b%b want %h %h %b%b%b%b", c,
                 pre_n, clr_n, busy, done, err, req_ready,
                 e_pre, e_clr, e_busy, e_done, e_err, e_ready);
      end
    end
    checks++;
    if (done_edge - acc !== P + G) begin
      failures++;
      $display("FAIL clear_done_lat got %0d want %0d", done_edge - acc, P + G);
    end
  endtask

  task automatic test_write();
    req_valid = 1'b1;
    req_op    = 2'b11;
    req_mask  = 8'hFF;
    req_data  = 8'hA5;
    for (int c = 0; c < 6; c++) begin
      step();
      req_valid = 1'b0;
      req_data  = 8'h00;
      checks++;
      if ({pre_n, clr_n, busy, done, err, req_ready} !==
          {e_pre, e_clr, e_busy, e_done, e_err, e_ready} ||
          (~pre_n & ~clr_n) !== '0) begin
        failures++;
        $display("FAIL write c=%0d got %h %h %b%b%b%b want %h %h %b%b%b%b", c,
                 pre_n, clr_n, busy, done, err, req_ready,
                 e_pre, e_clr, e_busy, e_done, e_err, e_ready);
      end
    end
    checks++;
    if (bank !== 8'hA5) begin
      failures++;
      $display("FAIL write_bank got %h want A5", bank);
    end
  endtask

  task automatic test_reserved();
    req_valid = 1'b1;
    req_op    = 2'b00;
    req_mask  = 8'hFF;
    for (int c = 0; c < 3; c++) begin
      step();
      req_valid = 1'b0;
      checks++;
      if ({pre_n, clr_n, busy, done, err, req_ready} !==
          {e_pre, e_clr, e_busy, e_done, e_err, e_ready}) begin
        failures++;
        $display("FAIL reserved c=%0d got %h %h %b%b%b%b want %h %h %b%b%b%b",
                 c, pre_n, clr_n, busy, done, err, req_ready,
                 e_pre, e_clr, e_busy, e_done, e_err, e_ready);
      end
    end
  endtask

  task automatic test_back_to_back();
    dacc_q.delete();
    req_valid = 1'b1;
    req_op    = 2'b10;
    req_mask  = 8'h3C;
    for (int c = 0; c < 10; c++) begin
      step();
      if (dacc_q.size() >= 1) begin
        req_op   = 2'b01;
        req_mask = 8'hC3;
      end
      if (dacc_q.size() >= 2) req_valid = 1'b0;
      checks++;
      if ({pre_n, clr_n, busy, done, err, req_ready} !==
          {e_pre, e_clr, e_busy, e_done, e_err, e_ready} ||
          (~pre_n & ~clr_n) !== '0) begin
        failures++;
        $display("FAIL b2b c=%0d got %h %h %b%b%b%b want %h %h %b%b%b%b", c,
                 pre_n, clr_n, busy, done, err, req_ready,
                 e_pre, e_clr, e_busy, e_done, e_err, e_ready);
      end
    end
    checks++;
    if (dacc_q.size() < 2) begin
      failures++;
      $display("FAIL b2b_accepts got %0d want 2", dacc_q.size());
    end else if (dacc_q[1] - dacc_q[0] !== P + G + 2) begin
      failures++;
      $display("FAIL b2b_gap got %0d want %0d", dacc_q[1] - dacc_q[0], P + G + 2);
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    req_valid = 1'b1;
    req_op    = 2'b10;
    req_mask  = 8'hFF;
    step();
    req_valid = 1'b0;
    checks++;
    if (pre_n !== 8'h00) begin
      failures++;
      $display("FAIL mid_pulse got pre=%h want 00", pre_n);
    end
    #2 clr = 1'b0;
    #1;
    checks++;
    if ({pre_n, clr_n, busy, done} !== {8'hFF, 8'hFF, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL mid_async got %h %h %b%b want FF FF 00",
               pre_n, clr_n, busy, done);
    end
    m_active = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (done !== 1'b0 || pre_n !== 8'hFF) begin
        failures++;
        $display("FAIL mid_held got done=%b pre=%h want 0 FF", done, pre_n);
      end
    end
    clr = 1'b1;
    step();
    checks++;
    if ({req_ready, busy, done} !== 3'b100) begin
      failures++;
      $display("FAIL mid_release got rdy/busy/done=%b%b%b want 100",
               req_ready, busy, done);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_op    = 2'($urandom_range(0, 3));
      req_mask  = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
      req_data  = N'($urandom);
      step();
      checks++;
      if ({pre_n, clr_n, busy, done, err, req_ready} !==
          {e_pre, e_clr, e_busy, e_done, e_err, e_ready} ||
          (~pre_n & ~clr_n) !== '0) begin
        failures++;
        $display("FAIL random c=%0d got %h %h %b%b%b%b want %h %h %b%b%b%b", c,
                 pre_n, clr_n, busy, done, err, req_ready,
                 e_pre, e_clr, e_busy, e_done, e_err, e_ready);
      end
    end
    req_valid = 1'b0;
  endtask

  initial begin
    #1 clr = 1'b0;
    test_reset();
    step();
    test_clear();
    test_write();
    test_reserved();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
